// File: rtl/cpu_pkg.sv
// Shared encodings for the breadboard CPU: opcodes, T-states and control-word bit positions.
// The RAM, ALU and register blocks decode the same control word, so they all use these indices.
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int STEP_W   = 3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_JUMP  = 1;
    localparam int CW_PC_OUT   = 2;
    localparam int CW_MAR_LOAD = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_RAM_LOAD = 5;
    localparam int CW_IR_LOAD  = 6;
    localparam int CW_IR_OUT   = 7;
    localparam int CW_A_LOAD   = 8;
    localparam int CW_A_OUT    = 9;
    localparam int CW_B_LOAD   = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_ALU_SUB  = 12;
    localparam int CW_OUT_LOAD = 13;
    localparam int CW_WIDTH    = 14;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

    // One-hot control word with a single line asserted; OR these together to build a micro-op.
    function automatic ctrl_word_t cw(input int idx);
        ctrl_word_t word;
        word = '0;
        word[idx] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/control_step_counter.sv
// T-state counter: advances each cycle, returns to T0 at the end of an instruction,
// and is held at T0 while the machine is halted.
module control_step_counter
    import cpu_pkg::*;
#(
    parameter int STEP_WIDTH = STEP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  end_step,
    input  logic                  freeze,
    output logic [STEP_WIDTH-1:0] step
);

    logic [STEP_WIDTH-1:0] step_q;
    logic [STEP_WIDTH-1:0] step_d;

    // T4 is the last legal state; anything at or beyond it wraps so a corrupted count self-recovers.
    always_comb begin
        step_d = step_q + STEP_WIDTH'(1);
        if (freeze || end_step || (step_q >= STEP_WIDTH'(T4))) begin
            step_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: sequences fetch/execute T-states, decodes the IR opcode into
// control lines, keeps the carry/zero flags for conditional jumps and latches HLT.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int STEP_WIDTH   = STEP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] ir_opcode,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    pc_inc,
    output logic                    pc_jump,
    output logic                    pc_out,
    output logic                    mar_load,
    output logic                    ram_out,
    output logic                    ram_load,
    output logic                    ir_load,
    output logic                    ir_out,
    output logic                    a_load,
    output logic                    a_out,
    output logic                    b_load,
    output logic                    alu_out,
    output logic                    alu_sub,
    output logic                    out_load,
    output logic                    halt,
    output logic [STEP_WIDTH-1:0]   step
);

    logic carry_q, carry_d;
    logic zero_q, zero_d;
    logic halted_q, halted_d;

    logic       end_instr;
    logic       flags_load;
    logic       set_halt;
    ctrl_word_t ctrl_raw;
    ctrl_word_t ctrl;

    control_step_counter #(
        .STEP_WIDTH(STEP_WIDTH)
    ) u_step_counter (
        .clk      (clk),
        .rst_n    (rst),
        .end_step (end_instr),
        .freeze   (halted_q),
        .step     (step)
    );

    // Fetch is opcode-independent; the opcode is only trusted from T2 onwards.
    always_comb begin
        ctrl_raw   = '0;
        end_instr  = 1'b0;
        flags_load = 1'b0;
        set_halt   = 1'b0;
        case (step)
            STEP_WIDTH'(T0): ctrl_raw = cw(CW_PC_OUT) | cw(CW_MAR_LOAD);
            STEP_WIDTH'(T1): ctrl_raw = cw(CW_RAM_OUT) | cw(CW_IR_LOAD) | cw(CW_PC_INC);
            STEP_WIDTH'(T2): begin
                case (ir_opcode)
                    OPCODE_WIDTH'(OP_NOP): end_instr = 1'b1;
                    OPCODE_WIDTH'(OP_LDA),
                    OPCODE_WIDTH'(OP_ADD),
                    OPCODE_WIDTH'(OP_SUB),
                    OPCODE_WIDTH'(OP_STA): ctrl_raw = cw(CW_IR_OUT) | cw(CW_MAR_LOAD);
                    OPCODE_WIDTH'(OP_LDI): begin
                        ctrl_raw  = cw(CW_IR_OUT) | cw(CW_A_LOAD);
                        end_instr = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_JMP): begin
                        ctrl_raw  = cw(CW_IR_OUT) | cw(CW_PC_JUMP);
                        end_instr = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_JC): begin
                        ctrl_raw  = cw(CW_IR_OUT) | (carry_q ? cw(CW_PC_JUMP) : '0);
                        end_instr = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_JZ): begin
                        ctrl_raw  = cw(CW_IR_OUT) | (zero_q ? cw(CW_PC_JUMP) : '0);
                        end_instr = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_OUT): begin
                        ctrl_raw  = cw(CW_A_OUT) | cw(CW_OUT_LOAD);
                        end_instr = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_HLT): begin
                        end_instr = 1'b1;
                        set_halt  = 1'b1;
                    end
                    default: end_instr = 1'b1;
                endcase
            end
            STEP_WIDTH'(T3): begin
                // A 3-cycle opcode seen here means the IR changed mid-instruction; just finish.
                end_instr = 1'b1;
                case (ir_opcode)
                    OPCODE_WIDTH'(OP_LDA): ctrl_raw = cw(CW_RAM_OUT) | cw(CW_A_LOAD);
                    OPCODE_WIDTH'(OP_ADD),
                    OPCODE_WIDTH'(OP_SUB): begin
                        ctrl_raw  = cw(CW_RAM_OUT) | cw(CW_B_LOAD);
                        end_instr = 1'b0;
                    end
                    OPCODE_WIDTH'(OP_STA): ctrl_raw = cw(CW_A_OUT) | cw(CW_RAM_LOAD);
                    default: ctrl_raw = '0;
                endcase
            end
            STEP_WIDTH'(T4): begin
                end_instr = 1'b1;
                case (ir_opcode)
                    OPCODE_WIDTH'(OP_ADD): begin
                        ctrl_raw   = cw(CW_ALU_OUT) | cw(CW_A_LOAD);
                        flags_load = 1'b1;
                    end
                    OPCODE_WIDTH'(OP_SUB): begin
                        ctrl_raw   = cw(CW_ALU_OUT) | cw(CW_A_LOAD) | cw(CW_ALU_SUB);
                        flags_load = 1'b1;
                    end
                    default: ctrl_raw = '0;
                endcase
            end
            default: end_instr = 1'b1;
        endcase

        if (halted_q) begin
            ctrl_raw   = '0;
            end_instr  = 1'b1;
            flags_load = 1'b0;
            set_halt   = 1'b0;
        end
    end

    always_comb begin
        carry_d  = carry_q;
        zero_d   = zero_q;
        halted_d = halted_q | set_halt;
        if (flags_load) begin
            carry_d = alu_carry;
            zero_d  = alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
        end
    end

    // Reset gates the outputs directly so the datapath is quiet even before any clock edge.
    assign ctrl = rst ? ctrl_raw : '0;
    assign halt = rst & halted_q;

    assign pc_inc   = ctrl[CW_PC_INC];
    assign pc_jump  = ctrl[CW_PC_JUMP];
    assign pc_out   = ctrl[CW_PC_OUT];
    assign mar_load = ctrl[CW_MAR_LOAD];
    assign ram_out  = ctrl[CW_RAM_OUT];
    assign ram_load = ctrl[CW_RAM_LOAD];
    assign ir_load  = ctrl[CW_IR_LOAD];
    assign ir_out   = ctrl[CW_IR_OUT];
    assign a_load   = ctrl[CW_A_LOAD];
    assign a_out    = ctrl[CW_A_OUT];
    assign b_load   = ctrl[CW_B_LOAD];
    assign alu_out  = ctrl[CW_ALU_OUT];
    assign alu_sub  = ctrl[CW_ALU_SUB];
    assign out_load = ctrl[CW_OUT_LOAD];

    a_pc_exclusive : assert property (@(posedge clk) disable iff (!rst) !(pc_inc && pc_jump));
    a_one_bus_driver : assert property (@(posedge clk) disable iff (!rst)
        $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));
    a_step_range : assert property (@(posedge clk) disable iff (!rst) step <= STEP_WIDTH'(T4));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class T-state by T-state
// and compares every control line against hand-written micro-op tables.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ir_opcode = 4'h0;
    logic       alu_carry = 1'b0;
    logic       alu_zero = 1'b0;
    logic pc_inc, pc_jump, pc_out, mar_load, ram_out, ram_load, ir_load, ir_out;
    logic a_load, a_out, b_load, alu_out, alu_sub, out_load, halt;
    logic [2:0] step;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_out(pc_out), .mar_load(mar_load),
        .ram_out(ram_out), .ram_load(ram_load), .ir_load(ir_load), .ir_out(ir_out),
        .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
        .alu_sub(alu_sub), .out_load(out_load), .halt(halt), .step(step)
    );

    logic [13:0] ctrl_obs;
    assign ctrl_obs = {out_load, alu_sub, alu_out, b_load, a_out, a_load, ir_out, ir_load,
                       ram_load, ram_out, mar_load, pc_out, pc_jump, pc_inc};

    localparam logic [13:0] C_PC_INC   = 14'h0001;
    localparam logic [13:0] C_PC_JUMP  = 14'h0002;
    localparam logic [13:0] C_PC_OUT   = 14'h0004;
    localparam logic [13:0] C_MAR_LOAD = 14'h0008;
    localparam logic [13:0] C_RAM_OUT  = 14'h0010;
    localparam logic [13:0] C_RAM_LOAD = 14'h0020;
    localparam logic [13:0] C_IR_LOAD  = 14'h0040;
    localparam logic [13:0] C_IR_OUT   = 14'h0080;
    localparam logic [13:0] C_A_LOAD   = 14'h0100;
    localparam logic [13:0] C_A_OUT    = 14'h0200;
    localparam logic [13:0] C_B_LOAD   = 14'h0400;
    localparam logic [13:0] C_ALU_OUT  = 14'h0800;
    localparam logic [13:0] C_ALU_SUB  = 14'h1000;
    localparam logic [13:0] C_OUT_LOAD = 14'h2000;
    localparam logic [13:0] F0 = C_PC_OUT | C_MAR_LOAD;
    localparam logic [13:0] F1 = C_RAM_OUT | C_IR_LOAD | C_PC_INC;

    typedef struct packed {
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [2:0]  s;
        logic [13:0] ctrl;
    } vec_t;

    function automatic vec_t mk(logic [3:0] op, logic c, logic z, logic [2:0] s, logic [13:0] ctrl);
        vec_t v;
        v.op = op; v.c = c; v.z = z; v.s = s; v.ctrl = ctrl;
        return v;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== 18'h0)
                $display("FAIL reset_hold cyc%0d: got halt=%b step=%0d ctrl=%h, want all zero",
                         i, halt, step, ctrl_obs);
            else n_pass++;
        end
        @(posedge clk); #2; rst = 1'b1; #1;
        n_checks++;
        if ({halt, step, ctrl_obs} !== {1'b0, 3'd0, F0})
            $display("FAIL reset_release: got halt=%b step=%0d ctrl=%h, want halt=0 step=0 ctrl=%h",
                     halt, step, ctrl_obs, F0);
        else n_pass++;
    endtask

    task automatic test_lda();
        vec_t v[$];
        v.push_back(mk(4'h1, 0, 0, 3'd0, F0));
        v.push_back(mk(4'h1, 0, 0, 3'd1, F1));
        v.push_back(mk(4'h1, 0, 0, 3'd2, C_IR_OUT | C_MAR_LOAD));
        v.push_back(mk(4'h1, 1, 1, 3'd3, C_RAM_OUT | C_A_LOAD));
        v.push_back(mk(4'h0, 0, 0, 3'd0, F0));
        v.push_back(mk(4'h0, 0, 0, 3'd1, F1));
        v.push_back(mk(4'h0, 0, 0, 3'd2, 14'h0));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL lda cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
    endtask

    task automatic test_add_jc();
        vec_t v[$];
        v.push_back(mk(4'h2, 0, 1, 3'd0, F0));
        v.push_back(mk(4'h2, 0, 1, 3'd1, F1));
        v.push_back(mk(4'h2, 0, 1, 3'd2, C_IR_OUT | C_MAR_LOAD));
        v.push_back(mk(4'h2, 0, 1, 3'd3, C_RAM_OUT | C_B_LOAD));
        v.push_back(mk(4'h2, 1, 0, 3'd4, C_ALU_OUT | C_A_LOAD));
        v.push_back(mk(4'h7, 0, 1, 3'd0, F0));
        v.push_back(mk(4'h7, 0, 1, 3'd1, F1));
        v.push_back(mk(4'h7, 0, 1, 3'd2, C_IR_OUT | C_PC_JUMP));
        v.push_back(mk(4'h8, 0, 1, 3'd0, F0));
        v.push_back(mk(4'h8, 0, 1, 3'd1, F1));
        v.push_back(mk(4'h8, 0, 1, 3'd2, C_IR_OUT));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL add_jc cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
    endtask

    task automatic test_sub_jz_jc();
        vec_t v[$];
        v.push_back(mk(4'h3, 1, 0, 3'd0, F0));
        v.push_back(mk(4'h3, 1, 0, 3'd1, F1));
        v.push_back(mk(4'h3, 1, 0, 3'd2, C_IR_OUT | C_MAR_LOAD));
        v.push_back(mk(4'h3, 1, 0, 3'd3, C_RAM_OUT | C_B_LOAD));
        v.push_back(mk(4'h3, 0, 1, 3'd4, C_ALU_OUT | C_A_LOAD | C_ALU_SUB));
        v.push_back(mk(4'h8, 1, 0, 3'd0, F0));
        v.push_back(mk(4'h8, 1, 0, 3'd1, F1));
        v.push_back(mk(4'h8, 1, 0, 3'd2, C_IR_OUT | C_PC_JUMP));
        v.push_back(mk(4'h7, 1, 0, 3'd0, F0));
        v.push_back(mk(4'h7, 1, 0, 3'd1, F1));
        v.push_back(mk(4'h7, 1, 0, 3'd2, C_IR_OUT));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL sub_jz_jc cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
    endtask

    // Flags here stay C=0 Z=1 from the SUB above; the closing JZ confirms they were held.
    task automatic test_short_ops();
        vec_t v[$];
        logic [3:0]  ops[7];
        logic [13:0] t2[7];
        ops = '{4'h0, 4'h5, 4'h6, 4'hE, 4'hB, 4'h9, 4'hD};
        t2  = '{14'h0, C_IR_OUT | C_A_LOAD, C_IR_OUT | C_PC_JUMP, C_A_OUT | C_OUT_LOAD,
                14'h0, 14'h0, 14'h0};
        for (int k = 0; k < 7; k++) begin
            v.push_back(mk(ops[k], 1, 0, 3'd0, F0));
            v.push_back(mk(ops[k], 1, 0, 3'd1, F1));
            v.push_back(mk(ops[k], 1, 0, 3'd2, t2[k]));
        end
        v.push_back(mk(4'h4, 1, 0, 3'd0, F0));
        v.push_back(mk(4'h4, 1, 0, 3'd1, F1));
        v.push_back(mk(4'h4, 1, 0, 3'd2, C_IR_OUT | C_MAR_LOAD));
        v.push_back(mk(4'h4, 1, 0, 3'd3, C_A_OUT | C_RAM_LOAD));
        v.push_back(mk(4'h8, 0, 0, 3'd0, F0));
        v.push_back(mk(4'h8, 0, 0, 3'd1, F1));
        v.push_back(mk(4'h8, 0, 0, 3'd2, C_IR_OUT | C_PC_JUMP));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL short_ops cyc%0d op=%h: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, v[i].op, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_lda();
        vec_t v[$];
        v.push_back(mk(4'h1, 0, 0, 3'd0, F0));
        v.push_back(mk(4'h1, 0, 0, 3'd1, F1));
        v.push_back(mk(4'h1, 0, 0, 3'd2, C_IR_OUT | C_MAR_LOAD));
        v.push_back(mk(4'h1, 0, 0, 3'd3, C_RAM_OUT | C_A_LOAD));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL mid_lda cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
        rst = 1'b0; #1;
        n_checks++;
        if ({halt, step, ctrl_obs} !== 18'h0)
            $display("FAIL mid_lda_async: got halt=%b step=%0d ctrl=%h, want all zero", halt, step, ctrl_obs);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== 18'h0)
                $display("FAIL mid_lda_hold cyc%0d: got halt=%b step=%0d ctrl=%h, want all zero",
                         i, halt, step, ctrl_obs);
            else n_pass++;
        end
        @(posedge clk); #2; rst = 1'b1; #1;
        n_checks++;
        if ({halt, step, ctrl_obs} !== {1'b0, 3'd0, F0})
            $display("FAIL mid_lda_release: got halt=%b step=%0d ctrl=%h, want step=0 ctrl=%h",
                     halt, step, ctrl_obs, F0);
        else n_pass++;
        // Reset cleared zero_flag, so JZ must not jump.
        v.delete();
        v.push_back(mk(4'h8, 0, 1, 3'd0, F0));
        v.push_back(mk(4'h8, 0, 1, 3'd1, F1));
        v.push_back(mk(4'h8, 0, 1, 3'd2, C_IR_OUT));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL post_reset_jz cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
    endtask

    task automatic test_hlt();
        vec_t v[$];
        v.push_back(mk(4'hF, 0, 0, 3'd0, F0));
        v.push_back(mk(4'hF, 0, 0, 3'd1, F1));
        v.push_back(mk(4'hF, 0, 0, 3'd2, 14'h0));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL hlt cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ir_opcode = 4'(i); alu_carry = i[0]; alu_zero = i[1];
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b1, 3'd0, 14'h0})
                $display("FAIL halted cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=1 step=0 ctrl=0000",
                         i, halt, step, ctrl_obs);
            else n_pass++;
        end
        rst = 1'b0; #1;
        n_checks++;
        if ({halt, step, ctrl_obs} !== 18'h0)
            $display("FAIL hlt_reset: got halt=%b step=%0d ctrl=%h, want all zero", halt, step, ctrl_obs);
        else n_pass++;
        @(posedge clk); #2; rst = 1'b1; #1;
        v.delete();
        v.push_back(mk(4'h5, 0, 0, 3'd0, F0));
        v.push_back(mk(4'h5, 0, 0, 3'd1, F1));
        v.push_back(mk(4'h5, 0, 0, 3'd2, C_IR_OUT | C_A_LOAD));
        v.push_back(mk(4'h0, 0, 0, 3'd0, F0));
        foreach (v[i]) begin
            @(negedge clk);
            ir_opcode = v[i].op; alu_carry = v[i].c; alu_zero = v[i].z;
            #1;
            n_checks++;
            if ({halt, step, ctrl_obs} !== {1'b0, v[i].s, v[i].ctrl})
                $display("FAIL hlt_recover cyc%0d: got halt=%b step=%0d ctrl=%h, want halt=0 step=%0d ctrl=%h",
                         i, halt, step, ctrl_obs, v[i].s, v[i].ctrl);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_jc();
        test_sub_jz_jc();
        test_short_ops();
        test_reset_mid_lda();
        test_hlt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the breadboard CPU.
- Steps each instruction through fetch and execute T-states and decodes the instruction-register opcode.
- Drives the control lines of the program counter (increment, jump, bus drive), MAR, RAM, IR, A/B registers, ALU and output register.
- Latches ALU carry/zero flags for conditional jumps, and halts the machine on HLT.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field taken from the IR upper nibble.
- STEP_WIDTH, 3, width of the T-state counter (T0..T4 used).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- ir_opcode  input  OPCODE_WIDTH  opcode from the instruction register, valid from T2.
- alu_carry  input  1  ALU carry-out of the current result.
- alu_zero  input  1  ALU result-is-zero.
- pc_inc  output  1  program counter increment.
- pc_jump  output  1  program counter load from bus.
- pc_out  output  1  program counter drives bus.
- mar_load  output  1  MAR loads from bus.
- ram_out  output  1  RAM drives bus.
- ram_load  output  1  RAM writes bus at MAR.
- ir_load  output  1  IR loads from bus.
- ir_out  output  1  IR operand nibble drives bus.
- a_load  output  1  A register loads.
- a_out  output  1  A register drives bus.
- b_load  output  1  B register loads.
- alu_out  output  1  ALU drives bus.
- alu_sub  output  1  ALU subtract mode.
- out_load  output  1  output register loads.
- halt  output  1  CPU halted.
- step  output  STEP_WIDTH  current T-state (debug/LEDs).

Behaviour:
- State:
  - step counter, reset 0.
  - carry_flag and zero_flag, reset 0.
  - halted bit, reset 0.
- Reset:
  - rst=0 clears all state immediately, regardless of clk.
  - While rst=0, every control output is forced 0, including halt; step reads 0.
- Control outputs are combinational from (step, ir_opcode, flags, halted). There is no output register; each control is valid within the same cycle, and the target latches it on the next posedge.
- Fetch, same for every opcode:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute. "end" means step returns to 0 on the next posedge; otherwise step increments.
  - 0x0 NOP: T2 none; end.
  - 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load; end.
  - 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load, flags load; end.
  - 0x3 SUB: as ADD, with alu_sub asserted during T4 only.
  - 0x4 STA: T2 ir_out+mar_load; T3 a_out+ram_load; end.
  - 0x5 LDI: T2 ir_out+a_load; end.
  - 0x6 JMP: T2 ir_out+pc_jump; end.
  - 0x7 JC: T2 ir_out, plus pc_jump only if carry_flag=1; end.
  - 0x8 JZ: T2 ir_out, plus pc_jump only if zero_flag=1; end.
  - 0xE OUT: T2 a_out+out_load; end.
  - 0xF HLT: T2 no controls; sets halted at the posedge.
  - Undefined opcodes (0x9-0xD) behave as NOP.
- Flags:
  - Sampled from alu_carry/alu_zero at the posedge ending ADD/SUB T4.
  - Otherwise held.
- Halt:
  - While halted=1: halt=1, all other outputs 0, step frozen at 0.
  - Only reset clears halted.
- Exclusivity invariants:
  - pc_inc and pc_jump are never asserted together.
  - At most one bus driver is asserted at a time (pc_out, ram_out, ir_out, a_out, alu_out).
- Step never exceeds 4. If an out-of-range value appears, it forces return to 0.
- Instruction cycle lengths:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, OUT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_NOP..OP_HLT);
  - T-state constants T0..T4;
  - control-word bit indices, so that RAM, ALU and register blocks share the encoding.
- One natural sub-module: control_step_counter. It contains the step register with synchronous end/clear, async active-low reset, and a halt freeze.
- Decode and flag logic stay in control_sequencer.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-T3 of LDA -> step=0 and all outputs 0 immediately. After release, T0 shows pc_out=1, mar_load=1.
- LDA fetch/execute: ir_opcode=0x1 -> T0 {pc_out,mar_load}, T1 {ram_out,ir_load,pc_inc}, T2 {ir_out,mar_load}, T3 {ram_out,a_load}, then step=0.
- ADD with alu_carry=1, alu_zero=0 at T4 -> T4 {alu_out,a_load}, alu_sub=0. carry_flag=1 and zero_flag=0 after the edge. A following JC asserts pc_jump at T2.
- SUB with alu_zero=1 at T4 -> alu_sub=1 only in T4. A following JZ asserts pc_jump; a following JC (carry_flag cleared by the SUB, alu_carry=0) does not.
- HLT: ir_opcode=0xF -> after T2, halt=1 and step stays 0 for 20 cycles with all other controls 0. Only rst=0 restores fetch.
- Undefined 0xB -> 3-cycle instruction with no controls in T2; step sequence 0,1,2,0.
